fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

UART serial transmitter that drains the read side of the asynchronous FIFO in the transmit clock domain. Whenever the FIFO is non-empty, it pops one byte and shifts it out as a standard asynchronous serial frame on a single line: start bit, data bits LSB first, optional parity, stop bit. It sits directly downstream of the FIFO read port and drives the device TX pin.

## Interface
Parameters:
- Data_Width, 8, width of FIFO data word and number of data bits per frame
- Prescale_Width, 6, width of the PRESCALE input

Ports:
- CLK  input  1  transmit-domain clock, same clock as the FIFO read side
- RST  input  1  reset; synchronous, active-high
- FIFO_Empty  input  1  FIFO empty flag from the read side
- FIFO_Data  input  Data_Width  FIFO read data; show-ahead, valid whenever FIFO_Empty=0
- PRESCALE  input  Prescale_Width  CLK cycles per serial bit; 0 and 1 both mean 1
- R_INC  output  1  FIFO pop strobe; one CLK cycle per byte
- TX_OUT  output  1  serial line; idle high
- Busy  output  1  high while a frame is on the line

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Reset values, forced at any clock edge with RST=1, including mid-frame:
  - state=IDLE, TX_OUT=1, Busy=0, R_INC=0
  - bit and prescale counters = 0, shift register = 0
- A byte in flight at reset is lost. It is not re-popped.
- Pop condition: R_INC = !RST && !FIFO_Empty && (state==IDLE || last cycle of STOP).
  - R_INC is combinational from registered state and is never high for two consecutive cycles within one frame.
- On the edge where R_INC=1, the block latches:
  - FIFO_Data into the shift register
  - P = max(PRESCALE,1)
  - the parity controls, when the macro is defined
- Then state → START.
- The frame uses only these latched values. Changes to the inputs mid-frame have no effect.
- START: TX_OUT=0 for P cycles.
- DATA: Data_Width bits, LSB first, each for P cycles. A bit counter runs 0..Data_Width-1.
- STOP: TX_OUT=1 for P cycles.
  - On its last cycle, if FIFO_Empty=0, the block pops and goes to START. There is no idle gap between frames.
  - Otherwise it goes to IDLE.
- TX_OUT and Busy are registered. Busy=1 in START, DATA, PARITY and STOP.

## Timing
- Latency: FIFO_Empty falls in cycle n with state=IDLE → R_INC=1 in cycle n → TX_OUT=0 and Busy=1 from cycle n+1.
- Frame length: (Data_Width+2)·P cycles without parity, (Data_Width+3)·P cycles with parity enabled.
- Back-to-back frames: the start bit of the next frame begins on the cycle immediately after the last stop cycle. Busy stays high throughout.
- The prescale counter counts 0..P-1. A bit advances when the counter reaches P-1.
- Wrap-around: the bit counter resets to 0 on entering DATA.
- FIFO_Empty is sampled only in the pop-condition cycles. Its value at any other time is ignored.

## Configuration
- Macro: PARITY_EN.
- Defined:
  - adds input ports PAR_EN (1 bit) and PAR_TYP (1 bit: 0=even, 1=odd), both latched at pop
  - if the latched PAR_EN=1, a PARITY state of P cycles is inserted between DATA and STOP
  - parity bit: even = XOR of the data bits; odd = its inverse
  - if PAR_EN=0, the frame is identical to the undefined case
- Undefined: no PAR_EN or PAR_TYP ports, no PARITY state, fixed Data_Width+2 bit frame.

## Test plan
- Reset and idle:
  - Stimulus: RST=1 for 3 cycles with FIFO_Empty=0.
  - Required response: TX_OUT=1, Busy=0, R_INC=0 throughout. After release, R_INC=1 in the first cycle.
- Single frame:
  - Stimulus: FIFO_Data=0xA5, PRESCALE=1, one entry.
  - Required response: TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. Then IDLE with Busy=0 in cycle 11.
- Prescale:
  - Stimulus: 0x3C with PRESCALE=4.
  - Required response: each bit held exactly 4 cycles, 40-cycle frame, exactly one R_INC pulse.
- Back-to-back:
  - Stimulus: three entries 0x01, 0xFF, 0x80, PRESCALE=1.
  - Required response: 30 contiguous bit cycles, Busy constantly 1, R_INC pulses at cycles 0, 10, 20.
- Parity (PARITY_EN defined):
  - Stimulus: 0xA5 with PAR_EN=1, PAR_TYP=0; then PAR_TYP=1.
  - Required response: parity bit 0, then 1. Frame length 11 cycles.
- Reset mid-frame:
  - Stimulus: assert RST during data bit 3.
  - Required response: TX_OUT=1 and Busy=0 on the next edge. After release with FIFO_Empty=0, a new pop occurs and a full frame follows.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO read port: start, LSB-first data, stop.
// Define PARITY_EN to add PAR_EN/PAR_TYP ports and an optional parity bit per frame.
module fifo_uart_tx #(
    parameter int Data_Width     = 8,
    parameter int Prescale_Width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      FIFO_Empty,
    input  logic [Data_Width-1:0]     FIFO_Data,
    input  logic [Prescale_Width-1:0] PRESCALE,
`ifdef PARITY_EN
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
`endif
    output logic                      R_INC,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int BitCntWidth = (Data_Width > 2) ? $clog2(Data_Width) : 1;

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                    state_reg;
    logic [Prescale_Width-1:0] presc_cnt_reg;
    logic [Prescale_Width-1:0] p_reg;
    logic [BitCntWidth-1:0]    bit_cnt_reg;
    logic [Data_Width-1:0]     shift_reg;
    logic                      tx_reg;
    logic                      busy_reg;
`ifdef PARITY_EN
    logic                      par_en_reg;
    logic                      par_bit_reg;
`endif

    logic                      bit_end;
    logic                      last_data_bit;
    logic [Data_Width-1:0]     shift_next;

    assign bit_end       = (presc_cnt_reg == p_reg - Prescale_Width'(1));
    assign last_data_bit = (bit_cnt_reg == BitCntWidth'(Data_Width - 1));
    assign shift_next    = shift_reg >> 1;

    // Pop in idle, or on the final stop cycle so the next start bit follows with no gap.
    assign R_INC  = !RST && !FIFO_Empty &&
                    ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));
    assign TX_OUT = tx_reg;
    assign Busy   = busy_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            presc_cnt_reg <= '0;
            p_reg         <= Prescale_Width'(1);
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
`ifdef PARITY_EN
            par_en_reg    <= 1'b0;
            par_bit_reg   <= 1'b0;
`endif
        end else if (R_INC) begin
            // Everything the frame needs is captured here; later input changes are ignored.
            shift_reg     <= FIFO_Data;
            p_reg         <= (PRESCALE == '0) ? Prescale_Width'(1) : PRESCALE;
`ifdef PARITY_EN
            par_en_reg    <= PAR_EN;
            par_bit_reg   <= (^FIFO_Data) ^ PAR_TYP;
`endif
            presc_cnt_reg <= '0;
            state_reg     <= START;
            tx_reg        <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        presc_cnt_reg <= '0;
                        bit_cnt_reg   <= '0;
                        state_reg     <= DATA;
                        tx_reg        <= shift_reg[0];
                    end else begin
                        presc_cnt_reg <= presc_cnt_reg + Prescale_Width'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        presc_cnt_reg <= '0;
                        if (last_data_bit) begin
`ifdef PARITY_EN
                            if (par_en_reg) begin
                                state_reg <= PARITY;
                                tx_reg    <= par_bit_reg;
                            end else begin
                                state_reg <= STOP;
                                tx_reg    <= 1'b1;
                            end
`else
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BitCntWidth'(1);
                            shift_reg   <= shift_next;
                            tx_reg      <= shift_next[0];
                        end
                    end else begin
                        presc_cnt_reg <= presc_cnt_reg + Prescale_Width'(1);
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        presc_cnt_reg <= '0;
                        state_reg     <= STOP;
                        tx_reg        <= 1'b1;
                    end else begin
                        presc_cnt_reg <= presc_cnt_reg + Prescale_Width'(1);
                    end
                end
`endif
                STOP: begin
                    // Reaching here at bit_end means no pop was taken this cycle.
                    if (bit_end) begin
                        presc_cnt_reg <= '0;
                        state_reg     <= IDLE;
                        tx_reg        <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        presc_cnt_reg <= presc_cnt_reg + Prescale_Width'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-backed FIFO model feeds the DUT, a monitor decodes
// the serial line cycle by cycle against hand-computed frame patterns.
module tb_fifo_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       FIFO_Empty;
    logic [7:0] FIFO_Data;
    logic [5:0] PRESCALE;
    logic       R_INC;
    logic       TX_OUT;
    logic       Busy;
`ifdef PARITY_EN
    logic       PAR_EN;
    logic       PAR_TYP;
`endif

    fifo_uart_tx #(.Data_Width(8), .Prescale_Width(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FIFO_Empty (FIFO_Empty),
        .FIFO_Data  (FIFO_Data),
        .PRESCALE   (PRESCALE),
`ifdef PARITY_EN
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
`endif
        .R_INC      (R_INC),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // bits[0] is the start bit; frame bits listed in line order.
    typedef struct {
        logic [7:0]  data;
        logic [5:0]  presc;
        int          p;
        logic        par_en;
        logic        par_typ;
        logic [10:0] bits;
        int          nbits;
    } entry_t;

    entry_t fifo_q[$];
    entry_t exp_q[$];
    entry_t cur;

    int   errors = 0;
    int   checks = 0;
    bit   in_frame = 0;
    int   k = 0;
    logic r_inc_prev = 1'b0;
    logic r_inc_s = 1'b0;
    logic rst_at_edge = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void update_drive();
        if (fifo_q.size() != 0) begin
            FIFO_Empty = 1'b0;
            FIFO_Data  = fifo_q[0].data;
            PRESCALE   = fifo_q[0].presc;
`ifdef PARITY_EN
            PAR_EN     = fifo_q[0].par_en;
            PAR_TYP    = fifo_q[0].par_typ;
`endif
        end else begin
            // Garbage while empty: must never reach the line.
            FIFO_Empty = 1'b1;
            FIFO_Data  = 8'hEE;
            PRESCALE   = 6'd7;
`ifdef PARITY_EN
            PAR_EN     = 1'b1;
            PAR_TYP    = 1'b1;
`endif
        end
    endfunction

    task automatic push(input logic [7:0] data, input logic [5:0] presc, input int p,
                        input logic par_en, input logic par_typ,
                        input logic [10:0] bits, input int nbits);
        entry_t e;
        e.data = data; e.presc = presc; e.p = p; e.par_en = par_en;
        e.par_typ = par_typ; e.bits = bits; e.nbits = nbits;
        fifo_q.push_back(e);
        exp_q.push_back(e);
        update_drive();
    endtask

    always @(posedge CLK) rst_at_edge <= RST;
    always @(negedge CLK) r_inc_s = R_INC;

    // FIFO model: pop the front entry on every edge the DUT strobed R_INC.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (r_inc_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
            update_drive();
        end
    end

    // Monitor: decodes the line at each falling edge.
    initial begin
        repeat (2) @(posedge CLK);
        forever begin
            @(negedge CLK);
            if (RST) begin
                chk("rst_r_inc", R_INC, 0);
                in_frame = 0;  // byte in flight is lost
            end
            if (!in_frame && !RST && TX_OUT === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("start_after_pop", r_inc_prev, 1);
                    in_frame = 1;
                    k = 0;
                end
            end
            if (in_frame) begin
                chk($sformatf("tx_%02h_b%0d", cur.data, k / cur.p), TX_OUT, cur.bits[k / cur.p]);
                chk("busy_in_frame", Busy, 1);
                chk("r_inc_in_frame", R_INC,
                    ((k == cur.nbits * cur.p - 1) && !FIFO_Empty) ? 1 : 0);
                k++;
                if (k == cur.nbits * cur.p) in_frame = 0;
            end else if (!(RST && !rst_at_edge)) begin
                chk("idle_tx", TX_OUT, 1);
                chk("idle_busy", Busy, 0);
                if (!RST) chk("idle_r_inc", R_INC, !FIFO_Empty);
            end
            r_inc_prev = R_INC;
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #1;
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !in_frame) begin
                repeat (3) @(negedge CLK);
                @(posedge CLK);
                #2;
                return;
            end
        end
        chk("drain_timeout", 1, 0);
        exp_q.delete();
        fifo_q.delete();
        update_drive();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST = 1'b1;
        update_drive();
`ifdef PARITY_EN
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
`endif
        // Reset held with a byte waiting: no pop until release.
        push(8'h5A, 6'd2, 2, 0, 0, 11'h2B4, 10);
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_release_pop", R_INC, 1);
        wait_done();

        push(8'hA5, 6'd1, 1, 0, 0, 11'h34A, 10);
        wait_done();

        push(8'h3C, 6'd4, 4, 0, 0, 11'h278, 10);
        wait_done();

        push(8'h01, 6'd1, 1, 0, 0, 11'h202, 10);
        push(8'hFF, 6'd1, 1, 0, 0, 11'h3FE, 10);
        push(8'h80, 6'd1, 1, 0, 0, 11'h300, 10);
        wait_done();

        // PRESCALE=0 behaves as 1; mixed rates back to back.
        push(8'h96, 6'd0, 1, 0, 0, 11'h32C, 10);
        push(8'h55, 6'd3, 3, 0, 0, 11'h2AA, 10);
        push(8'hC3, 6'd1, 1, 0, 0, 11'h386, 10);
        wait_done();

`ifdef PARITY_EN
        push(8'hA5, 6'd1, 1, 1, 0, 11'h54A, 11);
        push(8'hA5, 6'd1, 1, 1, 1, 11'h74A, 11);
        push(8'hA5, 6'd2, 2, 0, 1, 11'h34A, 10);
        wait_done();
`endif

        // Reset during data bit 3 of 0xF0 (P=2); 0x0F waits in the FIFO.
        push(8'hF0, 6'd2, 2, 0, 0, 11'h3E0, 10);
        push(8'h0F, 6'd1, 1, 0, 0, 11'h21E, 10);
        begin
            bit popped = 0;
            for (int i = 0; i < 50 && !popped; i++) begin
                @(negedge CLK);
                if (R_INC) popped = 1;
            end
            chk("midrst_pop_seen", popped, 1);
        end
        @(posedge CLK);
        repeat (8) @(posedge CLK);
        #2;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_pop", R_INC, 1);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
